// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes, access size, FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_SECOND = 1'b1
   } state_e;

   // Low two funct3 bits encode the access width
   function automatic size_e f3_size(input logic [1:0] f3_lo);
      size_e s;
      s = SZ_WORD;
      case (f3_lo)
         2'd0:    s = SZ_BYTE;
         2'd1:    s = SZ_HALF;
         default: s = SZ_WORD;
      endcase
      return s;
   endfunction

   // Unsigned forms exist only for loads
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_wr);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_wr;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] size_bytes(input size_e s);
      logic [2:0] n;
      n = 3'd4;
      case (s)
         SZ_BYTE: n = 3'd1;
         SZ_HALF: n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic logic [3:0] size_lanes(input size_e s);
      logic [3:0] l;
      l = 4'b1111;
      case (s)
         SZ_BYTE: l = 4'b0001;
         SZ_HALF: l = 4'b0011;
         default: l = 4'b1111;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane alignment across a two-word window.
// Ports: funct3/offset select width and byte offset; wdata is LSB-justified store data;
// rd_lo/rd_hi are the first/second read words; lane_mask/wdata_sh give lanes and data
// for both words (low half = first word); rdata_ext is the extended load; crossing flags
// an access that spills into the next word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_lo,
   input  logic [31:0] rd_hi,
   output logic [7:0]  lane_mask,
   output logic [63:0] wdata_sh,
   output logic [31:0] rdata_ext,
   output logic        crossing
);

   size_e       size;
   logic [31:0] rd_sh;

   // 64-bit window lets split and non-split accesses share the same shifters
   always_comb begin
      size      = f3_size(funct3[1:0]);
      lane_mask = {4'b0000, size_lanes(size)} << offset;
      wdata_sh  = {32'h0, wdata} << {offset, 3'b000};
      rd_sh     = 32'({rd_hi, rd_lo} >> {offset, 3'b000});
      crossing  = ({1'b0, offset} + size_bytes(size)) > 3'd4;
      rdata_ext = rd_sh;
      case (size)
         SZ_BYTE: rdata_ext = funct3[2] ? {24'h0, rd_sh[7:0]}
                                        : {{24{rd_sh[7]}}, rd_sh[7:0]};
         SZ_HALF: rdata_ext = funct3[2] ? {16'h0, rd_sh[15:0]}
                                        : {{16{rd_sh[15]}}, rd_sh[15:0]};
         default: rdata_ext = rd_sh;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit with optional splitting of word-crossing accesses.
// Ports: clk, rst (async active-low); req_* request from execute; dmem_sel/wr/mask/addr/
// dmem_data_wr combinational cache request; dmem_data_rd cache read word; rdata/rdata_valid
// registered load result; stall combinational hold for upstream; err registered illegal-op pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit SPLIT_EN = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [2:0]  funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        dmem_sel,
   output logic        wr,
   output logic [3:0]  mask,
   output logic [31:0] addr,
   output logic [31:0] dmem_data_wr,
   input  logic [31:0] dmem_data_rd,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        stall,
   output logic        err
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic [31:0] part_q, part_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        err_q, err_d;

   logic        second, legal, acc_first, bad;
   logic [31:0] cur_addr, cur_wdata, rd_lo, rd_hi;
   logic [2:0]  cur_f3;
   logic [7:0]  lane_mask;
   logic [63:0] wdata_sh;
   logic [31:0] rdata_ext;
   logic        crossing;

   // In SECOND the aligner works on the latched request and the saved first read
   always_comb begin
      second    = (state_q == S_SECOND);
      cur_addr  = second ? addr_q  : req_addr;
      cur_f3    = second ? f3_q    : funct3;
      cur_wdata = second ? wdata_q : req_wdata;
      rd_lo     = second ? part_q  : dmem_data_rd;
      rd_hi     = second ? dmem_data_rd : 32'h0;
   end

   lsu_align u_align (
      .funct3    (cur_f3),
      .offset    (cur_addr[1:0]),
      .wdata     (cur_wdata),
      .rd_lo     (rd_lo),
      .rd_hi     (rd_hi),
      .lane_mask (lane_mask),
      .wdata_sh  (wdata_sh),
      .rdata_ext (rdata_ext),
      .crossing  (crossing)
   );

   // Cache request, stall and next-state logic
   always_comb begin
      dmem_sel      = 1'b0;
      wr            = 1'b0;
      mask          = 4'b0000;
      addr          = 32'h0;
      dmem_data_wr  = 32'h0;
      stall         = 1'b0;
      state_d       = state_q;
      addr_d        = addr_q;
      f3_d          = f3_q;
      wdata_d       = wdata_q;
      wr_d          = wr_q;
      part_d        = part_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;

      legal     = f3_legal(funct3, req_wr);
      acc_first = rst && !second && req_valid && legal && (!crossing || SPLIT_EN);
      bad       = !second && req_valid && (!legal || (crossing && !SPLIT_EN));
      err_d     = bad;

      if (acc_first) begin
         dmem_sel     = 1'b1;
         wr           = req_wr;
         addr         = {req_addr[31:2], 2'b00};
         mask         = lane_mask[3:0];
         dmem_data_wr = wdata_sh[31:0];
         stall        = crossing;
         if (crossing) begin
            state_d = S_SECOND;
            addr_d  = req_addr;
            f3_d    = funct3;
            wdata_d = req_wdata;
            wr_d    = req_wr;
            part_d  = req_wr ? 32'h0 : dmem_data_rd;
         end else if (!req_wr) begin
            rdata_d       = rdata_ext;
            rdata_valid_d = 1'b1;
         end
      end

      // Second half of a split access; address wraps naturally at 32 bits
      if (second && rst) begin
         dmem_sel     = 1'b1;
         wr           = wr_q;
         addr         = {addr_q[31:2], 2'b00} + 32'd4;
         mask         = lane_mask[7:4];
         dmem_data_wr = wdata_sh[63:32];
         state_d      = S_IDLE;
         if (!wr_q) begin
            rdata_d       = rdata_ext;
            rdata_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         addr_q        <= 32'h0;
         f3_q          <= 3'd0;
         wdata_q       <= 32'h0;
         wr_q          <= 1'b0;
         part_q        <= 32'h0;
         rdata_q       <= 32'h0;
         rdata_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         f3_q          <= f3_d;
         wdata_q       <= wdata_d;
         wr_q          <= wr_d;
         part_q        <= part_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         err_q         <= err_d;
      end
   end

   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign err         = err_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SPLIT_EN, default 1, meaning 1 = split word-crossing accesses into two cache accesses, 0 = flag them as err without access.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a memory op this cycle.
REQ-005 req_wr  in  1  1 = store, 0 = load.
REQ-006 funct3  in  3  RV32I width code (LB/SB=0, LH/SH=1, LW/SW=2, LBU=4, LHU=5).
REQ-007 req_addr  in  32  byte address; req_wdata  in  32  store data (LSB-justified).
REQ-008 dmem_sel, wr  out  1 each  cache select and write strobe.
REQ-009 mask  out  4  byte-lane enables; addr  out  32  word-aligned (addr[1:0]=0); dmem_data_wr  out  32  lane-shifted store data.
REQ-010 dmem_data_rd  in  32  combinational cache read word.
REQ-011 rdata  out  32  extended load result; rdata_valid  out  1  one-cycle pulse.
REQ-012 stall  out  1  upstream holds its request; err  out  1  one-cycle pulse for illegal op.

Function
REQ-013 FSM states IDLE and SECOND; reset state IDLE.
REQ-014 Access size: byte for funct3 0/4, half for 1/5, word for 2; funct3 3/6/7 (and 4/5 with req_wr=1) are illegal.
REQ-015 Illegal op in IDLE: no cache access (dmem_sel=0), err=1 next cycle, stall=0.
REQ-016 Crossing = (req_addr[1:0] + size_bytes) > 4; only halves at offset 3 and words at offsets 1-3 cross.
REQ-017 IDLE, legal, non-crossing: same cycle dmem_sel=1, wr=req_wr, addr={req_addr[31:2],2'b00}, mask=size bits shifted left by req_addr[1:0], dmem_data_wr=req_wdata shifted left by 8*req_addr[1:0]; stall=0.
REQ-018 Non-crossing load: posedge captures dmem_data_rd shifted right by 8*offset, zero/sign-extends per funct3 into rdata; rdata_valid=1 for the following cycle (latency 1).
REQ-019 IDLE, crossing, SPLIT_EN=1: cycle 1 accesses low word with lanes offset..3, stall=1, latches addr/funct3/wdata/wr and (loads) the partial read; next state SECOND.
REQ-020 SECOND: ignores req_* inputs; accesses word at latched addr+4 (32-bit wrap, 0xFFFFFFFC+4 -> 0x0) with remaining low lanes; stall=0; posedge assembles rdata (low bytes from first read) and pulses rdata_valid for loads; returns to IDLE.
REQ-021 Crossing with SPLIT_EN=0: treated as illegal per REQ-015.
REQ-022 Stores never assert rdata_valid; rdata holds its last value except on load completion.
REQ-023 req_valid=0 in IDLE: dmem_sel=0, wr=0, mask=0, dmem_data_wr=0.
REQ-024 dmem_sel, wr, mask, addr, dmem_data_wr are combinational from state, latched request and req_*; all are 0 while rst low.

Reset
REQ-025 rst low asynchronously forces IDLE, rdata=0, rdata_valid=0, err=0, latched request/partial regs=0, stall=0.
REQ-026 rst asserted in SECOND aborts the split: second access is not issued, no rdata_valid; store half already written is not undone.
REQ-027 After rst deasserts the first posedge may accept a request.

Structure
REQ-028 Package lsu_pkg holds funct3 encodings, size enum, FSM state enum.
REQ-029 One combinational sub-module lsu_align: lane mask, store shift, load shift and extension.

Verification
REQ-030 Word 0x100=0xAABBCCDD; LB at 0x101 -> rdata=0xFFFFFFCC, rdata_valid 1 cycle later; LBU -> 0x000000CC.
REQ-031 SH wdata=0x00001234 at 0x102 -> mask=4'b1100, dmem_data_wr=0x12340000, addr=0x100, stall=0.
REQ-032 0x100=0xAABBCCDD, 0x104=0x11223344; LW at 0x103 -> stall 1 cycle, accesses 0x100 then 0x104, rdata=0x223344AA.
REQ-033 SW 0xDEADBEEF at 0x102 -> mask 1100 data 0xBEEF0000 at 0x100, then mask 0011 data 0x0000DEAD at 0x104.
REQ-034 funct3=3 with req_valid=1 -> dmem_sel=0, err pulse, no rdata_valid; SPLIT_EN=0 with LW at 0x101 -> same.
REQ-035 rst low during SECOND of split store -> no access to second word, state IDLE, all outputs 0.
